// File: rtl/alu_md_unit_pkg.sv
// alu_md_unit_pkg: shared opcode/funct constants, ALU control and FSM encodings
package alu_md_unit_pkg;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [5:0] FUNCT_ADD   = 6'h20;
  localparam logic [5:0] FUNCT_SUB   = 6'h22;
  localparam logic [5:0] FUNCT_AND   = 6'h24;
  localparam logic [5:0] FUNCT_OR    = 6'h25;
  localparam logic [5:0] FUNCT_SLT   = 6'h2A;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_MFHI, ALU_MFLO,
    ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU, ALU_ILL
  } alu_ctl_e;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX} md_state_e;

  function automatic logic is_md(input alu_ctl_e c);
    return c inside {ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU};
  endfunction

  function automatic logic is_div(input alu_ctl_e c);
    return c inside {ALU_DIV, ALU_DIVU};
  endfunction

  function automatic logic is_signed_op(input alu_ctl_e c);
    return c inside {ALU_MULT, ALU_DIV};
  endfunction
endpackage

// File: rtl/alu_md_unit_md_iter.sv
// md_iter: WIDTH-cycle shift-add multiplier / restoring divider on operand magnitudes
module md_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam int CW = $clog2(WIDTH) + 1;
  logic [CW-1:0]    r_cnt;
  logic             r_div;
  logic [WIDTH-1:0] r_acc, r_q, r_b;
  logic [WIDTH-1:0] w_ma, w_mb;
  logic [WIDTH:0]   w_sum, w_rem, w_diff;
  assign w_ma   = (is_signed && a[WIDTH-1]) ? -a : a;
  assign w_mb   = (is_signed && b[WIDTH-1]) ? -b : b;
  assign w_sum  = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);
  assign w_rem  = {r_acc, r_q[WIDTH-1]};
  assign w_diff = w_rem - {1'b0, r_b};
  assign done   = (r_cnt == CW'(1));
  assign hi_o   = r_acc;
  assign lo_o   = r_q;
  // one multiply or divide step per cycle while the counter runs down
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (start) begin
      r_cnt <= CW'(WIDTH);
      r_div <= is_div;
      r_acc <= '0;
      r_q   <= w_ma;
      r_b   <= w_mb;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
      r_acc <= r_div ? (w_diff[WIDTH] ? w_rem[WIDTH-1:0] : w_diff[WIDTH-1:0]) : w_sum[WIDTH:1];
      r_q   <= r_div ? {r_q[WIDTH-2:0], ~w_diff[WIDTH]} : {w_sum[0], r_q[WIDTH-1:1]};
    end
  end
endmodule

// File: rtl/alu_md_unit.sv
// alu_md_unit: decoding ALU with iterative mult/div, HI/LO registers and valid/ready handshake
module alu_md_unit
  import alu_md_unit_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MD_ENABLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       aluop,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam logic MD_EN = (MD_ENABLE != 0);
  md_state_e        r_state, w_state_nx;
  alu_ctl_e         w_ctl;
  logic             w_acc, w_div0, w_start, w_done;
  logic             r_is_div, r_neg, r_rneg, r_div0;
  logic [WIDTH-1:0] r_a, w_sc, w_md_hi, w_md_lo, w_q, w_r, w_hi_new, w_lo_new;
  logic [2*WIDTH-1:0] w_prod, w_prod_fx;
  assign in_ready = (r_state == ST_IDLE);
  assign w_acc    = in_valid && in_ready;
  assign w_div0   = is_div(w_ctl) && (b == '0);
  assign w_start  = w_acc && is_md(w_ctl) && !w_div0;
  // aluop/funct to internal control; mult/div/mfhi/mflo only when enabled
  always_comb begin
    w_ctl = ALU_ILL;
    if (aluop == ALUOP_ADD) w_ctl = ALU_ADD;
    else if (aluop == ALUOP_SUB) w_ctl = ALU_SUB;
    else
      case (funct)
        FUNCT_ADD:   w_ctl = ALU_ADD;
        FUNCT_SUB:   w_ctl = ALU_SUB;
        FUNCT_AND:   w_ctl = ALU_AND;
        FUNCT_OR:    w_ctl = ALU_OR;
        FUNCT_SLT:   w_ctl = ALU_SLT;
        FUNCT_MULT:  w_ctl = MD_EN ? ALU_MULT : ALU_ILL;
        FUNCT_MULTU: w_ctl = MD_EN ? ALU_MULTU : ALU_ILL;
        FUNCT_DIV:   w_ctl = MD_EN ? ALU_DIV : ALU_ILL;
        FUNCT_DIVU:  w_ctl = MD_EN ? ALU_DIVU : ALU_ILL;
        FUNCT_MFHI:  w_ctl = MD_EN ? ALU_MFHI : ALU_ILL;
        FUNCT_MFLO:  w_ctl = MD_EN ? ALU_MFLO : ALU_ILL;
        default:     w_ctl = ALU_ILL;
      endcase
  end
  // single-cycle result; illegal ops yield zero
  always_comb begin
    w_sc = w_ctl == ALU_ADD  ? a + b :
           w_ctl == ALU_SUB  ? a - b :
           w_ctl == ALU_AND  ? a & b :
           w_ctl == ALU_OR   ? a | b :
           w_ctl == ALU_SLT  ? {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)} :
           w_ctl == ALU_MFHI ? hi :
           w_ctl == ALU_MFLO ? lo : '0;
  end
  md_iter #(.WIDTH(WIDTH)) u_md (
    .clk(clk), .reset(reset), .start(w_start), .is_div(is_div(w_ctl)),
    .is_signed(is_signed_op(w_ctl)), .a(a), .b(b),
    .done(w_done), .hi_o(w_md_hi), .lo_o(w_md_lo)
  );
  // sign correction of the magnitude results, applied in FIX
  assign w_prod    = {w_md_hi, w_md_lo};
  assign w_prod_fx = r_neg ? -w_prod : w_prod;
  assign w_q       = r_neg ? -w_md_lo : w_md_lo;
  assign w_r       = r_rneg ? -w_md_hi : w_md_hi;
  assign w_hi_new  = r_div0 ? r_a : r_is_div ? w_r : w_prod_fx[2*WIDTH-1:WIDTH];
  assign w_lo_new  = r_div0 ? '1 : r_is_div ? w_q : w_prod_fx[WIDTH-1:0];
  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else r_state <= w_state_nx;
  end
  // FSM next state; divide by zero skips the iteration
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE: if (w_acc && is_md(w_ctl)) w_state_nx = w_div0 ? ST_FIX : ST_RUN;
      ST_RUN:  if (w_done) w_state_nx = ST_FIX;
      ST_FIX:  w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end
  // operand sign capture, HI/LO writeback and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
      div0      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      r_is_div  <= 1'b0;
      r_neg     <= 1'b0;
      r_rneg    <= 1'b0;
      r_div0    <= 1'b0;
      r_a       <= '0;
    end else begin
      out_valid <= 1'b0;
      illegal   <= 1'b0;
      div0      <= 1'b0;
      if (w_acc) begin
        r_is_div <= is_div(w_ctl);
        r_neg    <= is_signed_op(w_ctl) && (a[WIDTH-1] ^ b[WIDTH-1]);
        r_rneg   <= is_signed_op(w_ctl) && a[WIDTH-1];
        r_div0   <= w_div0;
        r_a      <= a;
        if (!is_md(w_ctl)) begin
          out_valid <= 1'b1;
          result    <= w_sc;
          zero      <= (w_sc == '0);
          illegal   <= (w_ctl == ALU_ILL);
        end
      end
      if (r_state == ST_FIX) begin
        out_valid <= 1'b1;
        hi        <= w_hi_new;
        lo        <= w_lo_new;
        result    <= w_lo_new;
        zero      <= (w_lo_new == '0);
        div0      <= r_div0;
      end
    end
  end
endmodule

// File: tb/tb_alu_md_unit.sv
// tb_alu_md_unit: scoreboard bench for alu_md_unit at WIDTH=32
module tb_alu_md_unit;
  typedef struct {
    logic [31:0] res, hi, lo;
    logic z, ill, d0;
    int due;
  } exp_t;

  logic clk = 0, reset = 1, in_valid = 0;
  logic [1:0] aluop = 0;
  logic [5:0] funct = 0;
  logic [31:0] a = 0, b = 0;
  logic in_ready, out_valid, zero, illegal, div0;
  logic [31:0] result, hi, lo;
  int checks = 0, errors = 0, cyc = 0;
  logic [31:0] m_hi = 0, m_lo = 0;
  exp_t sb[$];

  alu_md_unit #(.WIDTH(32), .MD_ENABLE(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .aluop(aluop), .funct(funct), .a(a), .b(b), .out_valid(out_valid),
    .result(result), .zero(zero), .illegal(illegal), .div0(div0), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    logic [63:0] p;
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.ill = 0; e.d0 = 0; e.due = 1; e.res = 0;
    if (op == 2'b00) e.res = x + y;
    else if (op == 2'b01) e.res = x - y;
    else
      case (fn)
        6'h20: e.res = x + y;
        6'h22: e.res = x - y;
        6'h24: e.res = x & y;
        6'h25: e.res = x | y;
        6'h2A: e.res = (sx < sy) ? 32'd1 : 32'd0;
        6'h10: e.res = m_hi;
        6'h12: e.res = m_lo;
        6'h18, 6'h19: begin
          p = (fn == 6'h18) ? 64'(sx * sy) : {32'b0, x} * {32'b0, y};
          {m_hi, m_lo} = p;
          e.res = m_lo; e.due = 34;
        end
        6'h1A, 6'h1B: begin
          if (y == 0) begin
            m_lo = '1; m_hi = x; e.d0 = 1; e.due = 2;
          end else if (fn == 6'h1A) begin
            m_lo = 32'(sx / sy); m_hi = 32'(sx % sy); e.due = 34;
          end else begin
            m_lo = x / y; m_hi = x % y; e.due = 34;
          end
          e.res = m_lo;
        end
        default: e.ill = 1;
      endcase
    e.z = (e.res == 0);
    e.hi = m_hi;
    e.lo = m_lo;
    return e;
  endfunction

  // drive an op, hold it until accepted, push its expected outcome
  task automatic issue(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    int n = 0;
    aluop = op; funct = fn; a = x; b = y; in_valid = 1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", 0, 1);
    e = model(op, fn, x, y);
    e.due += cyc;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 0;
    a = $urandom; b = $urandom; funct = 6'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(sb.size()), 0);
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) check("spurious_out_valid", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("latency", 64'(cyc), 64'(e.due));
        check("result", result, e.res);
        check("zero", zero, e.z);
        check("illegal", illegal, e.ill);
        check("div0", div0, e.d0);
        check("hi", hi, e.hi);
        check("lo", lo, e.lo);
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_result", result, 0);
    reset = 0;
    @(negedge clk);
    issue(2'b10, 6'h20, 5, 7);
    issue(2'b10, 6'h22, 9, 9);
    issue(2'b10, 6'h2A, 32'hFFFFFFFF, 1);
    issue(2'b10, 6'h2A, 1, 32'hFFFFFFFF);
    issue(2'b10, 6'h3F, 1, 2);
    issue(2'b00, 6'h3F, 32'hFFFFFFFF, 3);
    issue(2'b01, 6'h00, 3, 4);
    issue(2'b11, 6'h24, 32'hF0F0_1234, 32'h0FF0_FF00);
    issue(2'b10, 6'h25, 32'hF000_0001, 32'h0000_1230);
    issue(2'b10, 6'h18, 32'hFFFFFFFE, 3);
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("mult_busy_cycles", 64'(n), 33);
    issue(2'b10, 6'h10, 0, 0);
    issue(2'b10, 6'h12, 0, 0);
    issue(2'b10, 6'h1A, 32'hFFFFFFF9, 2);
    issue(2'b10, 6'h1B, 7, 0);
    issue(2'b10, 6'h1A, 32'h80000000, 32'hFFFFFFFF);
    issue(2'b10, 6'h1A, 7, 32'hFFFFFFFE);
    issue(2'b10, 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF);
    issue(2'b10, 6'h18, 32'h80000000, 32'h80000000);
    issue(2'b10, 6'h1B, 32'hDEADBEEF, 32'h00001234);
    issue(2'b10, 6'h1A, 32'h12345678, 0);
    for (int i = 0; i < 4; i++) issue(2'b10, (i % 2) ? 6'h1A : 6'h18, $urandom, $urandom);
    issue(2'b10, 6'h19, 32'h0001_0000, 32'h0001_0000);
    issue(2'b00, 6'h00, 32'h11, 32'h22);
    issue(2'b10, 6'h10, 0, 0);
    drain();
    issue(2'b10, 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (9) @(negedge clk);
    reset = 1;
    @(negedge clk);
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    reset = 0;
    sb.delete();
    m_hi = 0;
    m_lo = 0;
    repeat (40) @(negedge clk);
    issue(2'b10, 6'h12, 0, 0);
    issue(2'b10, 6'h20, 32'hFFFFFFFF, 1);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
